// File: rtl/hcn_pkg.sv
// Shared opcode, condition and FSM definitions for the hcn accumulator-stack core.
package hcn_pkg;

  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_HALT} state_e;

  // store-group ALU operations (instruction bits [6:4])
  localparam logic [2:0] OP_SC  = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_NOT = 3'd6;
  localparam logic [2:0] OP_SA  = 3'd7;

  // upper-nibble groups
  localparam logic [3:0] GRP_LDBA = 4'h8;
  localparam logic [3:0] GRP_LDR  = 4'h9;
  localparam logic [3:0] GRP_LI   = 4'hA;

  localparam logic [7:0] INS_HLT = 8'hB0;
  localparam logic [7:0] INS_NOP = 8'hC0;

  // jump conditions (instruction bits [2:0]); 001 and 11x are never taken
  localparam logic [2:0] CC_JP  = 3'd0;
  localparam logic [2:0] CC_JC  = 3'd2;
  localparam logic [2:0] CC_JNC = 3'd3;
  localparam logic [2:0] CC_JZ  = 3'd4;
  localparam logic [2:0] CC_JNZ = 3'd5;

endpackage

// File: rtl/hcn_alu.sv
// Combinational ALU for the store group; carry is only meaningful for ADD/SUB.
module hcn_alu
  import hcn_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    op,
  output logic [DW-1:0] result,
  output logic          carry
);

  logic [DW:0] sum;

  // SUB is A + ~B + 1 so carry=1 means no borrow; SC is muxed in by the core
  always_comb begin
    sum    = '0;
    result = a;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DW-1:0];
        carry  = sum[DW];
      end
      OP_SUB: begin
        sum    = {1'b0, a} + {1'b0, ~b} + (DW+1)'(1);
        result = sum[DW-1:0];
        carry  = sum[DW];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_SA:   result = a;
      default: result = a;
    endcase
  end

endmodule

// File: rtl/hcn_core.sv
// hcn_core: tiny stack machine, FETCH/EXEC/HALT, byte instructions, local RAM.
module hcn_core
  import hcn_pkg::*;
#(
  parameter  int DW  = 4,
  parameter  int SD  = 3,
  parameter  int RAW = 2*DW,
  localparam int PCW = 3*DW
) (
  input  logic           clk,
  input  logic           nReset,
  output logic           imem_req,
  output logic [PCW-1:0] imem_addr,
  input  logic [7:0]     imem_data,
  input  logic           imem_valid,
  output logic [PCW-1:0] pc_out,
  output logic [DW-1:0]  stk_a_out,
  output logic [DW-1:0]  stk_b_out,
  output logic [DW-1:0]  stk_c_out,
  output logic [1:0]     flags_out,
  output logic           halted
);

  state_e                state, state_nxt;
  logic [7:0]            ir;
  logic [PCW-1:0]        pc, pc_nxt;
  logic [SD-1:0][DW-1:0] stk, stk_shift;
  logic                  carry, zero;
  logic [DW-1:0]         ram [2**RAW];

  logic           exec, is_store, is_ldba, is_ldr, is_li, is_hlt, is_jmp, push, take;
  logic [RAW-1:0] rd_addr, wr_addr;
  logic [DW-1:0]  push_val, alu_res, store_val;
  logic           alu_carry;

  assign exec     = (state == ST_EXEC);
  assign is_store = ~ir[7];
  assign is_ldba  = (ir[7:4] == GRP_LDBA);
  assign is_ldr   = (ir[7:4] == GRP_LDR);
  assign is_li    = (ir[7:4] == GRP_LI);
  assign is_hlt   = (ir == INS_HLT);
  assign is_jmp   = (ir[7:5] == 3'b111);
  assign push     = exec & (is_ldba | is_ldr | is_li);

  assign rd_addr  = is_ldba ? RAW'({stk[1], stk[0]}) : RAW'(ir[3:0]);
  assign wr_addr  = RAW'(ir[3:0]);
  assign push_val = is_li ? DW'(ir[3:0]) : ram[rd_addr];

  hcn_alu #(.DW(DW)) u_alu (
    .a      (stk[0]),
    .b      (stk[1]),
    .op     (ir[6:4]),
    .result (alu_res),
    .carry  (alu_carry)
  );

  assign store_val = (ir[6:4] == OP_SC) ? stk[2] : alu_res;

  // new level k is old level k-1; level 0 takes the pushed value
  for (genvar k = 0; k < SD; k++) begin : g_lvl
    if (k == 0) begin : g_top
      assign stk_shift[k] = push_val;
    end else begin : g_below
      assign stk_shift[k] = stk[k-1];
    end
  end

  // jump condition from flags as held on entry to EXEC
  always_comb begin
    take = 1'b0;
    case (ir[2:0])
      CC_JP:   take = 1'b1;
      CC_JC:   take = carry;
      CC_JNC:  take = ~carry;
      CC_JZ:   take = zero;
      CC_JNZ:  take = ~zero;
      default: take = 1'b0;
    endcase
  end

  // next pc: HLT freezes, taken jump loads {C,B,A}, otherwise wrap-around increment
  always_comb begin
    pc_nxt = pc + PCW'(1);
    if (is_hlt)              pc_nxt = pc;
    else if (is_jmp && take) pc_nxt = {stk[2], stk[1], stk[0]};
  end

  // FSM next state and fetch request
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) state_nxt = ST_EXEC;
      end
      ST_EXEC: state_nxt = is_hlt ? ST_HALT : ST_FETCH;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_FETCH;
    endcase
  end

  // architectural state; all updates commit in the single EXEC cycle
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state <= ST_FETCH;
      ir    <= INS_NOP;
      pc    <= '0;
      stk   <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_FETCH && imem_valid) ir <= imem_data;
      if (exec) pc <= pc_nxt;
      if (push) stk <= stk_shift;
      if (exec && is_store) begin
        zero <= (store_val == '0);
        if (ir[6:4] == OP_ADD || ir[6:4] == OP_SUB) carry <= alu_carry;
      end
    end
  end

  // data RAM, deliberately not reset
  always_ff @(posedge clk) begin
    if (exec && is_store) ram[wr_addr] <= store_val;
  end

  assign imem_addr = pc;
  assign pc_out    = pc;
  assign stk_a_out = stk[0];
  assign stk_b_out = stk[1];
  assign stk_c_out = stk[2];
  assign flags_out = {carry, zero};
  assign halted    = (state == ST_HALT);

endmodule

// File: tb/tb_hcn_core.sv
// Scoreboard bench for hcn_core: two instances (DW=4/SD=3 and DW=8/SD=5), one active at a time.
module tb_hcn_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nReset = 1'b0;
  logic       sel = 1'b0;
  logic       imem_valid = 1'b0;
  logic [7:0] imem_data = 8'h00;

  logic        req0, h0, req1, h1;
  logic [11:0] addr0, pc0;
  logic [3:0]  a0, b0, c0;
  logic [1:0]  f0, f1;
  logic [23:0] addr1, pc1;
  logic [7:0]  a1, b1, c1;

  hcn_core u_dut0 (
    .clk(clk), .nReset(nReset & ~sel), .imem_req(req0), .imem_addr(addr0),
    .imem_data(imem_data), .imem_valid(imem_valid & ~sel), .pc_out(pc0),
    .stk_a_out(a0), .stk_b_out(b0), .stk_c_out(c0), .flags_out(f0), .halted(h0)
  );

  hcn_core #(.DW(8), .SD(5)) u_dut1 (
    .clk(clk), .nReset(nReset & sel), .imem_req(req1), .imem_addr(addr1),
    .imem_data(imem_data), .imem_valid(imem_valid & sel), .pc_out(pc1),
    .stk_a_out(a1), .stk_b_out(b1), .stk_c_out(c1), .flags_out(f1), .halted(h1)
  );

  // view of whichever instance is active
  logic        o_req, o_halt;
  logic [23:0] o_addr, o_pc;
  logic [7:0]  o_a, o_b, o_c;
  logic [1:0]  o_f;
  always_comb begin
    o_req  = sel ? req1  : req0;
    o_halt = sel ? h1    : h0;
    o_addr = sel ? addr1 : {12'h0, addr0};
    o_pc   = sel ? pc1   : {12'h0, pc0};
    o_a    = sel ? a1    : {4'h0, a0};
    o_b    = sel ? b1    : {4'h0, b0};
    o_c    = sel ? c1    : {4'h0, c0};
    o_f    = sel ? f1    : f0;
  end

  typedef struct { logic [31:0] pc, a, b, c, fl, h; } exp_t;
  typedef struct { logic [7:0] ins; int lat; } item_t;
  exp_t  exp_q[$];
  item_t prog_q[$];

  int checks = 0, failures = 0;

  // reference model state
  int dw = 4, sd = 3;
  int m_pc;
  int m_stk[5];
  bit m_c, m_z, m_h;
  int m_ram[2][16];
  bit wr[2][16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic m_push(input int v);
    for (int k = sd - 1; k > 0; k--) m_stk[k] = m_stk[k-1];
    m_stk[0] = v;
  endtask

  // instruction semantics written straight from the ISA description
  task automatic model_exec(input logic [7:0] ins);
    int mask, pmask, A, B, C, lo, r, s, nxt, addr;
    bit t;
    exp_t e;
    mask  = (1 << dw) - 1;
    pmask = (1 << (3*dw)) - 1;
    A = m_stk[0]; B = m_stk[1]; C = m_stk[2]; lo = int'(ins[3:0]);
    nxt = (m_pc + 1) & pmask;
    r = 0;
    if (ins[7] == 1'b0) begin
      case (ins[6:4])
        3'd0: r = C;
        3'd1: begin s = A + B;              r = s & mask; m_c = (s > mask); end
        3'd2: begin s = A + (mask - B) + 1; r = s & mask; m_c = (s > mask); end
        3'd3: r = A & B;
        3'd4: r = A | B;
        3'd5: r = A ^ B;
        3'd6: r = mask - A;
        default: r = A;
      endcase
      m_ram[sel][lo] = r;
      m_z = (r == 0);
    end else if (ins[7:4] == 4'h8) begin
      addr = (B << dw) | A;
      m_push(addr < 16 ? m_ram[sel][addr] : 0);
    end else if (ins[7:4] == 4'h9) begin
      m_push(m_ram[sel][lo]);
    end else if (ins[7:4] == 4'hA) begin
      m_push(lo);
    end else if (ins == 8'hB0) begin
      m_h = 1'b1;
      nxt = m_pc;
    end else if (ins[7:5] == 3'b111) begin
      case (ins[2:0])
        3'd0: t = 1'b1;
        3'd2: t = m_c;
        3'd3: t = !m_c;
        3'd4: t = m_z;
        3'd5: t = !m_z;
        default: t = 1'b0;
      endcase
      if (t) nxt = (C << (2*dw)) | (B << dw) | A;
    end
    m_pc = nxt;
    e.pc = m_pc; e.a = m_stk[0]; e.b = m_stk[1]; e.c = m_stk[2];
    e.fl = {30'd0, m_c, m_z}; e.h = {31'd0, m_h};
    exp_q.push_back(e);
  endtask

  // instruction-memory responder: random latency, feeds queued bytes in order
  initial begin
    int wait_cnt = 0;
    item_t it;
    forever begin
      @(negedge clk);
      imem_valid = 1'b0;
      if (nReset && o_req && prog_q.size() > 0) begin
        if (wait_cnt < prog_q[0].lat) begin
          wait_cnt++;
          chk("wait_req", {31'd0, o_req}, 32'd1);
          chk("wait_pc", {8'd0, o_pc}, m_pc);
          chk("wait_stk_a", {24'd0, o_a}, m_stk[0]);
        end else begin
          it = prog_q.pop_front();
          wait_cnt = 0;
          chk("fetch_addr", {8'd0, o_addr}, m_pc);
          imem_valid = 1'b1;
          imem_data  = it.ins;
          model_exec(it.ins);
        end
      end
    end
  end

  // monitor: one retirement per EXEC cycle, compared against the scoreboard head
  initial begin
    bit prev_exec = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!nReset) prev_exec = 1'b0;
      else begin
        if (prev_exec) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL retire_unexpected actual=retire expected=none t=%0t", $time);
          end else begin
            e = exp_q.pop_front();
            chk("pc", {8'd0, o_pc}, e.pc);
            chk("stk_a", {24'd0, o_a}, e.a);
            chk("stk_b", {24'd0, o_b}, e.b);
            chk("stk_c", {24'd0, o_c}, e.c);
            chk("flags", {30'd0, o_f}, e.fl);
            chk("halted", {31'd0, o_halt}, e.h);
          end
        end
        prev_exec = !o_req && !o_halt;
      end
    end
  end

  task automatic send(input logic [7:0] ins, input int lat);
    item_t it;
    it.ins = ins; it.lat = lat;
    if (ins[7] == 1'b0) wr[sel][ins[3:0]] = 1'b1;
    prog_q.push_back(it);
  endtask

  task automatic drain();
    int n = 0;
    while ((prog_q.size() > 0 || exp_q.size() > 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("drain_timeout", 32'd1, 32'd0);
    #1;
  endtask

  // async reset mid-cycle, check reset values, then first fetch right after release
  task automatic do_reset(input bit s);
    @(negedge clk);
    #2;
    nReset = 1'b0;
    sel = s;
    prog_q.delete();
    exp_q.delete();
    dw = s ? 8 : 4;
    sd = s ? 5 : 3;
    m_pc = 0; m_c = 0; m_z = 0; m_h = 0;
    for (int k = 0; k < 5; k++) m_stk[k] = 0;
    #1;
    chk("rst_pc", {8'd0, o_pc}, 32'd0);
    chk("rst_stk", {8'd0, o_a, o_b, o_c}, 32'd0);
    chk("rst_flags", {30'd0, o_f}, 32'd0);
    chk("rst_halted", {31'd0, o_halt}, 32'd0);
    @(negedge clk);
    #2;
    nReset = 1'b1;
    @(negedge clk);
    #1;
    chk("first_fetch_req", {31'd0, o_req}, 32'd1);
    chk("first_fetch_addr", {8'd0, o_addr}, 32'd0);
  endtask

  task automatic rand_prog(input int n);
    logic [7:0] ins;
    int addr;
    for (int i = 0; i < n; i++) begin
      ins = 8'($urandom_range(0, 255));
      if (ins == 8'hB0) ins = 8'hC0;
      if (ins[7:4] == 4'h9 && !wr[sel][ins[3:0]]) ins = {4'hA, ins[3:0]};
      if (ins[7:4] == 4'h8) begin
        drain();
        addr = (m_stk[1] << dw) | m_stk[0];
        if (!(addr < 16 && wr[sel][addr])) ins = {4'hA, ins[3:0]};
      end
      send(ins, $urandom_range(0, 3));
    end
    drain();
  endtask

  initial begin
    #900000;
    failures++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    // LI 3; LI 5; ADD r2; LD r2
    do_reset(1'b0);
    send(8'hA3, 0); send(8'hA5, 1); send(8'h12, 2); send(8'h92, 0);
    drain();
    chk("t37_stk_a", {24'd0, o_a}, 32'd8);
    chk("t37_flags", {30'd0, o_f}, 32'd0);
    chk("t37_pc", {8'd0, o_pc}, 32'd4);

    // LI F; LI 1; ADD r0 -> wrap to zero with carry, then JZ to {0,1,0}
    do_reset(1'b0);
    send(8'hAF, 0); send(8'hA1, 0); send(8'h10, 0);
    drain();
    chk("t38_flags", {30'd0, o_f}, 32'd3);
    send(8'hA0, 0); send(8'hA1, 0); send(8'hA0, 0); send(8'hE4, 0);
    drain();
    chk("t38_pc", {8'd0, o_pc}, 32'h010);
    send(8'h90, 0);
    drain();
    chk("t38_ram0", {24'd0, o_a}, 32'd0);

    // fetch stall: valid withheld five cycles
    send(8'hA7, 5);
    drain();

    // HLT at pc=7, hold, then reset out of HALT
    do_reset(1'b0);
    for (int i = 0; i < 7; i++) send(8'hC0, $urandom_range(0, 2));
    send(8'hB0, 0);
    drain();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("halt_flag", {31'd0, o_halt}, 32'd1);
      chk("halt_pc", {8'd0, o_pc}, 32'd7);
      chk("halt_req", {31'd0, o_req}, 32'd0);
    end
    do_reset(1'b0);
    send(8'hA9, 0);
    drain();
    chk("post_halt_a", {24'd0, o_a}, 32'd9);

    // random programs on the small core, with a reset in between
    rand_prog(150);
    do_reset(1'b0);
    rand_prog(150);

    // wide/deep core: six pushes overflow the 5-level stack
    do_reset(1'b1);
    for (int v = 1; v <= 6; v++) send(8'(8'hA0 + v), $urandom_range(0, 2));
    drain();
    chk("t41_a", {24'd0, o_a}, 32'd6);
    chk("t41_b", {24'd0, o_b}, 32'd5);
    chk("t41_c", {24'd0, o_c}, 32'd4);
    chk("t41_lvl3", {24'd0, u_dut1.stk[3]}, 32'd3);
    chk("t41_lvl4", {24'd0, u_dut1.stk[4]}, 32'd2);

    // build 0xFF via NOT, jump to 0xFFFFFF, then wrap on NOP
    send(8'hA0, 0); send(8'h60, 0);
    send(8'h90, 0); send(8'h90, 1); send(8'h90, 0);
    send(8'hE0, 0);
    drain();
    chk("t41_pc_max", {8'd0, o_pc}, 32'hFFFFFF);
    send(8'hC0, 0);
    drain();
    chk("t41_pc_wrap", {8'd0, o_pc}, 32'd0);

    rand_prog(150);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
